// File: rtl/noise_gate_pkg.sv
// Shared types and default level constants for the noise gate.
// The optional bypass port is enabled by defining NOISE_GATE_BYPASS_EN.
package noise_gate_pkg;

  typedef enum logic [2:0] {
    CLOSED  = 3'd0,
    ATTACK  = 3'd1,
    OPEN    = 3'd2,
    HOLD    = 3'd3,
    RELEASE = 3'd4
  } gate_state_t;

  localparam int DEFAULT_BITS_PER_LEVEL = 12;
  localparam int DEFAULT_ONE_LEVEL      = 1 << DEFAULT_BITS_PER_LEVEL;
  localparam int DEFAULT_OPEN_THR       = 256;
  localparam int DEFAULT_CLOSE_THR      = 128;
  localparam int DEFAULT_HOLD_SAMPLES   = 4;
  localparam int DEFAULT_ATTACK_STEP    = 512;
  localparam int DEFAULT_RELEASE_STEP   = 64;
  localparam int DEFAULT_ENV_SHIFT      = 2;

  // Magnitude of a 32-bit sample; the most negative value saturates to 2^31-1.
  function automatic logic [31:0] abs_sat(input logic signed [31:0] v);
    logic [31:0] r;
    r = v;
    if (v[31]) begin
      r = (v[30:0] == '0) ? 32'h7fff_ffff : 32'(-v);
    end
    return r;
  endfunction

endpackage

// File: rtl/noise_gate_envelope_follower.sv
// Envelope follower: |x| with saturation and a first-order smoother that
// moves env a 2^-env_shift fraction of the way toward |x| on each update.
module envelope_follower
  import noise_gate_pkg::*;
#(
  parameter int env_shift = DEFAULT_ENV_SHIFT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic signed [31:0] x,
  output logic        [31:0] env_next
);

  logic        [31:0] ax;
  logic        [31:0] env;
  logic signed [32:0] diff;
  logic signed [32:0] step;
  logic signed [32:0] sum;

  // NOTE: always_comb temporaries use blocking '=' and get a value on every
  // path, so no latch is inferred; registered state below uses '<=' only.
  always_comb begin
    ax       = abs_sat(x);
    diff     = $signed({1'b0, ax}) - $signed({1'b0, env});
    step     = diff >>> env_shift;
    sum      = $signed({1'b0, env}) + step;
    env_next = sum[32] ? '0 : sum[31:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      env <= '0;
    end else if (en) begin
      env <= env_next;
    end
  end

endmodule

// File: rtl/noise_gate.sv
// Noise gate: envelope-driven gain FSM with hysteresis, hold and ramped gain,
// feeding a single-entry valid/ready output register. Defining
// NOISE_GATE_BYPASS_EN adds a bypass input that passes x through unchanged.
module noise_gate
  import noise_gate_pkg::*;
#(
  parameter int bits_per_level = DEFAULT_BITS_PER_LEVEL,
  parameter int open_thr       = DEFAULT_OPEN_THR,
  parameter int close_thr      = DEFAULT_CLOSE_THR,
  parameter int hold_samples   = DEFAULT_HOLD_SAMPLES,
  parameter int attack_step    = DEFAULT_ATTACK_STEP,
  parameter int release_step   = DEFAULT_RELEASE_STEP,
  parameter int env_shift      = DEFAULT_ENV_SHIFT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [31:0] x,
  input  logic               in_valid,
  output logic               in_ready,
  output logic signed [31:0] out,
  output logic               out_valid,
  input  logic               out_ready,
`ifdef NOISE_GATE_BYPASS_EN
  input  logic               bypass,
`endif
  output logic        [2:0]  gate_state
);

  localparam int              GAIN_W    = bits_per_level + 1;
  localparam logic [GAIN_W-1:0] ONE_LEVEL = {1'b1, {bits_per_level{1'b0}}};
  localparam logic [32:0]     ONE_W     = 33'(ONE_LEVEL);
  localparam logic [32:0]     ATK_W     = 33'(attack_step);
  localparam logic [32:0]     REL_W     = 33'(release_step);
  localparam logic [31:0]     OPEN_T    = 32'(open_thr);
  localparam logic [31:0]     CLOSE_T   = 32'(close_thr);
  localparam logic [31:0]     HOLD_INIT = 32'(hold_samples);
  localparam logic            HOLD_EN   = (hold_samples > 0);

  gate_state_t        state;
  logic [GAIN_W-1:0]  gain;
  logic [31:0]        hold_cnt;
  logic [31:0]        env_next;
  logic               accept;
  logic               bypass_on;
  logic               gate_en;
  logic               above_open;
  logic               below_close;
  logic [32:0]        gain_up_w;
  logic [GAIN_W-1:0]  gain_up;
  logic [GAIN_W-1:0]  gain_dn;
  logic signed [63:0] x_wide;
  logic signed [63:0] gain_wide;
  logic signed [63:0] prod;
  logic signed [31:0] gated;

`ifdef NOISE_GATE_BYPASS_EN
  assign bypass_on = bypass;
`else
  assign bypass_on = 1'b0;
`endif

  assign in_ready   = !out_valid || out_ready;
  assign accept     = in_valid && in_ready;
  assign gate_en    = accept && !bypass_on;
  assign gate_state = state;

  envelope_follower #(
    .env_shift (env_shift)
  ) u_env (
    .clk      (clk),
    .rst      (rst),
    .en       (gate_en),
    .x        (x),
    .env_next (env_next)
  );

  assign above_open  = (env_next >= OPEN_T);
  assign below_close = (env_next < CLOSE_T);

  // Gain ramps are computed wide so steps larger than the range still clamp.
  always_comb begin
    gain_up_w = 33'(gain) + ATK_W;
    gain_up   = (gain_up_w >= ONE_W) ? ONE_LEVEL : gain_up_w[GAIN_W-1:0];
    gain_dn   = (33'(gain) <= REL_W) ? '0 : (gain - REL_W[GAIN_W-1:0]);
  end

  always_comb begin
    x_wide    = {{32{x[31]}}, x};
    gain_wide = {{(64 - GAIN_W){1'b0}}, gain};
    prod      = x_wide * gain_wide;
    gated     = 32'(prod >>> bits_per_level);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      out       <= bypass_on ? x : gated;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Transitions look at env_next so the decision uses the sample just taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CLOSED;
      gain     <= '0;
      hold_cnt <= '0;
    end else if (gate_en) begin
      case (state)
        CLOSED: begin
          gain <= '0;
          if (above_open) state <= ATTACK;
        end
        ATTACK: begin
          gain <= gain_up;
          if (below_close)               state <= RELEASE;
          else if (gain_up == ONE_LEVEL) state <= OPEN;
        end
        OPEN: begin
          gain <= ONE_LEVEL;
          if (below_close) begin
            if (HOLD_EN) begin
              hold_cnt <= HOLD_INIT;
              state    <= HOLD;
            end else begin
              state <= RELEASE;
            end
          end
        end
        HOLD: begin
          if (above_open) begin
            state <= OPEN;
          end else begin
            hold_cnt <= hold_cnt - 32'd1;
            if (hold_cnt <= 32'd1) state <= RELEASE;
          end
        end
        RELEASE: begin
          gain <= gain_dn;
          if (above_open)       state <= ATTACK;
          else if (gain_dn == '0) state <= CLOSED;
        end
        default: begin
          state <= CLOSED;
          gain  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_noise_gate.sv
// Directed testbench for noise_gate with default parameters; bypass scenario
// runs only when NOISE_GATE_BYPASS_EN is defined.
module tb_noise_gate;
  import noise_gate_pkg::*;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [31:0] x = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [31:0] out;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [2:0]         gate_state;
`ifdef NOISE_GATE_BYPASS_EN
  logic               bypass = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  logic signed [31:0] got[$];

  noise_gate dut (
    .clk        (clk),
    .rst        (rst),
    .x          (x),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out        (out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
`ifdef NOISE_GATE_BYPASS_EN
    .bypass     (bypass),
`endif
    .gate_state (gate_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) got.push_back(out);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic signed [31:0] v);
    x        = v;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic open_gate();
    do_reset();
    for (int i = 0; i < 12; i++) push(32'sd1000);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; x = 32'sd555;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    checks++;
    if (out !== 32'sd0) begin errors++; $display("FAIL reset_out: got %0d want 0", out); end
    checks++;
    if (gate_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", gate_state); end
    checks++;
    if (dut.u_env.env !== 32'd0) begin errors++; $display("FAIL reset_env: got %0d want 0", dut.u_env.env); end
    in_valid = 1'b0;
    rst      = 1'b0;
  endtask

  task automatic test_attack();
    int       exp_out[12] = '{0, 0, 0, 125, 250, 375, 500, 625, 750, 875, 1000, 1000};
    int       exp_st[12]  = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 2, 2, 2};
    int       exp_env[3]  = '{250, 437, 577};
    do_reset();
    for (int i = 0; i < 12; i++) begin
      push(32'sd1000);
      checks++;
      if (out !== exp_out[i]) begin errors++; $display("FAIL attack_out[%0d]: got %0d want %0d", i, out, exp_out[i]); end
      checks++;
      if (gate_state !== 3'(exp_st[i])) begin errors++; $display("FAIL attack_state[%0d]: got %0d want %0d", i, gate_state, exp_st[i]); end
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL attack_valid[%0d]: got %0b want 1", i, out_valid); end
      if (i < 3) begin
        checks++;
        if (dut.u_env.env !== 32'(exp_env[i])) begin errors++; $display("FAIL attack_env[%0d]: got %0d want %0d", i, dut.u_env.env, exp_env[i]); end
      end
    end
  endtask

  // Continues from the OPEN state left by test_attack.
  task automatic test_hold_release();
    int  n = 0;
    logic bad;
    while (gate_state !== 3'(HOLD) && n < 40) begin
      push(32'sd0);
      n++;
    end
    checks++;
    if (n >= 40) begin errors++; $display("FAIL hold_entry: got state %0d after %0d samples want %0d", gate_state, n, HOLD); end
    for (int k = 1; k <= 3; k++) begin
      push(32'sd0);
      checks++;
      if (gate_state !== 3'(HOLD) || out !== 32'sd0) begin
        errors++; $display("FAIL hold_sample[%0d]: got state %0d out %0d want state 3 out 0", k, gate_state, out);
      end
    end
    push(32'sd0);
    checks++;
    if (gate_state !== 3'(RELEASE)) begin errors++; $display("FAIL hold_to_release: got %0d want %0d", gate_state, RELEASE); end
    bad = 1'b0;
    for (int r = 1; r <= 63; r++) begin
      push(32'sd0);
      if (gate_state !== 3'(RELEASE) || out !== 32'sd0) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL release_ramp: got early exit want 63 samples in RELEASE"); end
    push(32'sd0);
    checks++;
    if (gate_state !== 3'(CLOSED)) begin errors++; $display("FAIL release_to_closed: got %0d want %0d", gate_state, CLOSED); end
    checks++;
    if (dut.gain !== 13'd0) begin errors++; $display("FAIL release_gain: got %0d want 0", dut.gain); end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic signed [31:0] want[3] = '{32'sd101, 32'sd102, 32'sd103};
    open_gate();
    push(32'sd101);
    got.delete();
    out_ready = 1'b0;
    x         = 32'sd102;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b0 || out !== 32'sd101 || out_valid !== 1'b1) begin
        errors++; $display("FAIL stall[%0d]: got ready %0b out %0d valid %0b want 0 101 1", c, in_ready, out, out_valid);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out !== 32'sd102) begin errors++; $display("FAIL stall_resume: got %0d want 102", out); end
    push(32'sd103);
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (got.size() != 3) begin
      errors++; $display("FAIL stall_count: got %0d outputs want 3", got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got[i] !== want[i]) begin errors++; $display("FAIL stall_data[%0d]: got %0d want %0d", i, got[i], want[i]); end
      end
    end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_drain: got valid %0b want 0", out_valid); end
  endtask

  task automatic test_min_neg();
    open_gate();
    x        = 32'sh8000_0000;
    in_valid = 1'b1;
    #1;
    checks++;
    if (dut.u_env.ax !== 32'h7fff_ffff) begin errors++; $display("FAIL min_neg_ax: got %0h want 7fffffff", dut.u_env.ax); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out !== 32'sh8000_0000) begin errors++; $display("FAIL min_neg_out: got %0h want 80000000", out); end
    checks++;
    if (gate_state !== 3'(OPEN)) begin errors++; $display("FAIL min_neg_state: got %0d want %0d", gate_state, OPEN); end
  endtask

  task automatic test_hold_reopen();
    int n = 0;
    open_gate();
    while (gate_state !== 3'(HOLD) && n < 40) begin
      push(32'sd0);
      n++;
    end
    checks++;
    if (n >= 40) begin errors++; $display("FAIL reopen_hold_entry: got state %0d want %0d", gate_state, HOLD); end
    for (int k = 0; k < 4; k++) begin
      push(32'sd4000);
      checks++;
      if (gate_state !== 3'(OPEN) || dut.gain !== 13'd4096 || out !== 32'sd4000) begin
        errors++; $display("FAIL reopen[%0d]: got state %0d gain %0d out %0d want 2 4096 4000", k, gate_state, dut.gain, out);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) push(32'sd1000);
    checks++;
    if (gate_state !== 3'(ATTACK) || out_valid !== 1'b1) begin
      errors++; $display("FAIL mid_pre: got state %0d valid %0b want 1 1", gate_state, out_valid);
    end
    rst      = 1'b1;
    x        = 32'sd1000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %0b want 0", out_valid); end
    checks++;
    if (gate_state !== 3'(CLOSED)) begin errors++; $display("FAIL mid_state: got %0d want 0", gate_state); end
    checks++;
    if (dut.u_env.env !== 32'd0 || dut.gain !== 13'd0) begin
      errors++; $display("FAIL mid_clear: got env %0d gain %0d want 0 0", dut.u_env.env, dut.gain);
    end
    in_valid = 1'b0;
    rst      = 1'b0;
  endtask

`ifdef NOISE_GATE_BYPASS_EN
  task automatic test_bypass();
    do_reset();
    for (int i = 0; i < 3; i++) push(32'sd1000);
    bypass = 1'b1;
    push(32'sd77);
    in_valid = 1'b0;
    bypass   = 1'b0;
    checks++;
    if (out !== 32'sd77) begin errors++; $display("FAIL bypass_out: got %0d want 77", out); end
    checks++;
    if (gate_state !== 3'(ATTACK) || dut.gain !== 13'd512 || dut.u_env.env !== 32'd577) begin
      errors++; $display("FAIL bypass_frozen: got state %0d gain %0d env %0d want 1 512 577", gate_state, dut.gain, dut.u_env.env);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_attack();
    test_hold_release();
    test_backpressure();
    test_min_neg();
    test_hold_reopen();
    test_reset_mid();
`ifdef NOISE_GATE_BYPASS_EN
    test_bypass();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
